// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that time-shares one N-bit ALU among R valid/ready requesters.
// Each request is granted, executed in a single cycle, then held as a tagged result until consumed.
module alu_rr_scheduler #(
    parameter int N   = 32,
    parameter int R   = 4,
    parameter int IDW = $clog2(R)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [R-1:0]     req_valid,
    output logic [R-1:0]     req_ready,
    input  logic [3*R-1:0]   req_op,
    input  logic [N*R-1:0]   req_a,
    input  logic [N*R-1:0]   req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [N-1:0]     rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [2:0]      r_op;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [N-1:0]    r_rsp_data;

    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [R-1:0]    w_ready;
    logic            w_accept;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
        return IDW'((int'(p) + k) % R);
    endfunction

    function automatic logic [N-1:0] alu(input logic [2:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
        logic [N-1:0] res;
        case (op)
            3'd0:    res = ~a;
            3'd1:    res = a & b;
            3'd2:    res = a | b;
            3'd3:    res = a ^ b;
            3'd4:    res = a + b;
            3'd5:    res = a - b;
            3'd6:    res = ($signed(a) < $signed(b)) ? N'(1) : '0;
            default: res = b;
        endcase
        return res;
    endfunction

    // Search starts just after the last winner so every requester is reached within R grants.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= R; k++) begin
            if (!w_found && req_valid[rr_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(r_ptr, k);
            end
        end
    end

    assign w_accept = (r_state == IDLE) && w_found && rst_n;

    always_comb begin
        w_ready = '0;
        if (w_accept) w_ready[w_win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= IDW'(R - 1);
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_ptr   <= w_win;
                        r_id    <= w_win;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= alu(r_op, r_a, r_b);
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operands are captured only on the accept edge; they need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op <= req_op[3*w_win +: 3];
            r_a  <= req_a[N*w_win +: N];
            r_b  <= req_b[N*w_win +: N];
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios plus random traffic, all outputs
// compared every cycle against a transaction-level round-robin/ALU reference.
module tb_alu_rr_scheduler;
    localparam int N   = 32;
    localparam int R   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [R-1:0]     req_valid = '0;
    logic [R-1:0]     req_ready;
    logic [3*R-1:0]   req_op = '0;
    logic [N*R-1:0]   req_a = '0;
    logic [N*R-1:0]   req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [IDW-1:0]   rsp_id;
    logic [N-1:0]     rsp_data;
    logic             busy;

    alu_rr_scheduler #(.N(N), .R(R), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pending requests seen by the requesters
    bit           p_vld [R];
    logic [2:0]   p_op  [R];
    logic [N-1:0] p_a   [R];
    logic [N-1:0] p_b   [R];
    bit           rsp_rdy_q;

    // Reference: last granted requester, and the one outstanding transaction
    int           m_ptr;
    bit           m_busy;
    int           m_age;
    int           m_id;
    logic [N-1:0] m_data;
    int           grants[$];

    logic [N-1:0] last_data;
    int           last_id;
    logic [R-1:0] last_rdy;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] ref_alu(input logic [2:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        case (op)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return N'((64'(a) + 64'(b)) % (64'd1 << N));
            3'd5: return N'((64'(a) + (64'd1 << N) - 64'(b)) % (64'd1 << N));
            3'd6: return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return b;
        endcase
    endfunction

    function automatic int rr_pick();
        for (int k = 1; k <= R; k++) begin
            if (p_vld[(m_ptr + k) % R]) return (m_ptr + k) % R;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < R; i++) begin
            req_valid[i]       = p_vld[i];
            req_op[3*i +: 3]   = p_op[i];
            req_a[N*i +: N]    = p_a[i];
            req_b[N*i +: N]    = p_b[i];
        end
        rsp_ready = rsp_rdy_q;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [N-1:0] a,
                           input logic [N-1:0] b);
        p_vld[i] = 1'b1;
        p_op[i]  = op;
        p_a[i]   = a;
        p_b[i]   = b;
    endtask

    // One clock: drive inputs at the falling edge, check all outputs, then advance the reference
    task automatic cycle();
        int           win;
        logic [R-1:0] exp_rdy;
        bit           exp_rv;
        @(negedge clk);
        drive();
        #1;
        win     = m_busy ? -1 : rr_pick();
        exp_rdy = (win >= 0) ? R'(1 << win) : '0;
        exp_rv  = m_busy && (m_age >= 1);
        last_rdy = req_ready;
        chk_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk_eq("busy", 64'(busy), 64'(m_busy));
        chk_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk_eq("rsp_id", 64'(rsp_id), 64'(m_id));
            chk_eq("rsp_data", 64'(rsp_data), 64'(m_data));
            last_id   = int'(rsp_id);
            last_data = rsp_data;
        end
        if (win >= 0) begin
            m_busy = 1'b1;
            m_age  = 0;
            m_id   = win;
            m_data = ref_alu(p_op[win], p_a[win], p_b[win]);
            m_ptr  = win;
            grants.push_back(win);
            p_vld[win] = 1'b0;
        end else if (m_busy) begin
            if (exp_rv && rsp_rdy_q) m_busy = 1'b0;
            else m_age++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < R; i++) p_vld[i] = 1'b0;
        m_ptr  = R - 1;
        m_busy = 1'b0;
        m_age  = 0;
    endtask

    task automatic check_in_reset();
        chk_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_req_ready", 64'(req_ready), 64'd0);
        chk_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_in_reset();
        model_reset();
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Accept a request, then pull reset after 'after' further cycles while it is in flight
    task automatic reset_in_flight(input int after);
        set_req(1, 3'd4, 32'h10, 32'h20);
        rsp_rdy_q = 1'b0;
        cycle();
        repeat (after) cycle();
        @(negedge clk);
        chk_eq("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_in_reset();
        model_reset();
        drive();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rsp_rdy_q = 1'b1;
        for (int i = 0; i < R; i++) set_req(i, 3'd0, '0, '0);
        model_reset();
        apply_reset();

        // Idle after reset
        repeat (10) cycle();

        // Single requester, NOT
        set_req(2, 3'd0, 32'h0000_00FF, 32'h1234_5678);
        cycle();
        chk_eq("t2_ready", 64'(last_rdy), 64'b0100);
        repeat (4) cycle();
        chk_eq("t2_id", 64'(last_id), 64'd2);
        chk_eq("t2_data", 64'(last_data), 64'hFFFF_FF00);

        // All four requesting continuously: strict rotation, one result per 3 cycles
        apply_reset();
        grants.delete();
        rsp_rdy_q = 1'b1;
        for (int c = 0; c < 15; c++) begin
            for (int i = 0; i < R; i++)
                if (!p_vld[i]) set_req(i, 3'($urandom_range(7)), $urandom, $urandom);
            cycle();
        end
        chk_eq("t3_count", 64'(grants.size()), 64'd5);
        begin
            int exp_order[5] = '{0, 1, 2, 3, 0};
            for (int g = 0; g < 5 && g < grants.size(); g++)
                chk_eq("t3_order", 64'(grants[g]), 64'(exp_order[g]));
        end
        for (int i = 0; i < R; i++) p_vld[i] = 1'b0;
        repeat (4) cycle();

        // Arithmetic corner cases from requester 1
        set_req(1, 3'd4, 32'hFFFF_FFFF, 32'd2);
        repeat (4) cycle();
        chk_eq("t4_add", 64'(last_data), 64'h0000_0001);
        set_req(1, 3'd5, 32'd0, 32'd1);
        repeat (4) cycle();
        chk_eq("t4_sub", 64'(last_data), 64'hFFFF_FFFF);
        set_req(1, 3'd6, 32'h8000_0000, 32'd1);
        repeat (4) cycle();
        chk_eq("t4_slt", 64'(last_data), 64'd1);
        chk_eq("t4_id", 64'(last_id), 64'd1);

        // Back-pressure with requester 3 waiting
        set_req(0, 3'd7, 32'hDEAD_BEEF, 32'h0000_1234);
        cycle();
        set_req(3, 3'd3, 32'hF0F0_F0F0, 32'hFFFF_0000);
        rsp_rdy_q = 1'b0;
        repeat (6) cycle();
        chk_eq("t5_hold_data", 64'(last_data), 64'h0000_1234);
        rsp_rdy_q = 1'b1;
        cycle();
        chk_eq("t5_rdy_handshake", 64'(last_rdy), 64'd0);
        cycle();
        chk_eq("t5_rdy_after", 64'(last_rdy), 64'b1000);
        repeat (4) cycle();
        chk_eq("t5_data3", 64'(last_data), 64'h0F0F_F0F0);

        // Reset while executing, and while holding a result
        reset_in_flight(0);
        reset_in_flight(2);
        set_req(0, 3'd2, 32'h0000_00F0, 32'h0000_000F);
        set_req(3, 3'd1, 32'hFFFF_FFFF, 32'h1);
        rsp_rdy_q = 1'b1;
        cycle();
        chk_eq("t6_first", 64'(last_rdy), 64'b0001);
        repeat (8) cycle();

        // Random traffic with random back-pressure and occasional withdrawn requests
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < R; i++) begin
                if (!p_vld[i] && $urandom_range(3) == 0)
                    set_req(i, 3'($urandom_range(7)), $urandom, $urandom);
                else if (p_vld[i] && !m_busy && $urandom_range(40) == 0)
                    p_vld[i] = 1'b0;
            end
            rsp_rdy_q = ($urandom_range(3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
